beta_fetch_ctrl: RTL and testbench
==================================

// Module: beta_fetch_ctrl
// PURPOSE
//  Read-side sequencer for the beta (partial-sum) storage of the SCAN decoder.
//  Accepts one node-read request (layer, node address) and issues the per-beat
//  r_en/layer_r/r_address/cntb sequence to the storage. Captures each P*Q beat
//  of b_out after the storage's 1-cycle read latency and assembles a zero-masked
//  4*P-lane vector, presented to the PE array over a valid/ready handshake.
// PARAMETERS
//  P  32  lanes per storage beat
//  Q  6   bits per beta value
// PORTS
//  clk        in   1        single clock, all logic on posedge
//  rst        in   1        asynchronous, active-high reset
//  req_valid  in   1        read request valid
//  req_ready  out  1        high only in IDLE
//  req_layer  in   5        node layer, legal 1..8
//  req_addr   in   9        node address (storage r_address)
//  r_en       out  1        storage read enable
//  layer_r    out  5        storage read layer
//  r_address  out  9        storage read address
//  cntb       out  5        storage beat index within node
//  b_out      in   P*Q      storage read data (registered in storage, 1-cycle latency)
//  vec_valid  out  1        assembled vector valid
//  vec_ready  in   1        consumer accepts vector
//  vec_out    out  4*P*Q    beat k in [(k+1)*P*Q-1 -: P*Q]
//  vec_err    out  1        request carried an illegal layer (qualified by vec_valid)
// BEHAVIOUR
//  - Reset (async): state=IDLE; req_ready=1; r_en, layer_r, r_address, cntb,
//    vec_valid, vec_err, vec_out all 0; capture pipeline cleared.
//  - Beats per layer: n=4 for layer 8, n=2 for layer 7, n=1 for layers 1..6.
//  - Valid lanes per beat: 32 for layer>=5, 2^layer for layers 1..4. Lanes at or
//    above that count, and beats >= n, are forced to 0 in vec_out.
//  - FSM IDLE -> ISSUE -> DRAIN -> DONE -> IDLE.
//    IDLE: req_ready=1. At edge with req_valid&&req_ready: latch layer/addr,
//      clear vec_out and vec_err, set beat counter=0. Legal layer -> ISSUE;
//      illegal layer (0 or >8) -> DONE with vec_err=1 and no storage read.
//    ISSUE: r_en=1, layer_r=latched layer, r_address=latched addr, cntb=counter;
//      counter increments each cycle; after beat n-1 -> DRAIN.
//    DRAIN: r_en=0; one cycle to capture the final beat -> DONE.
//    DONE: vec_valid=1; vec_out, vec_err stable while vec_ready=0;
//      at edge with vec_ready=1 -> IDLE.
//  - Storage outputs are decoded from registered state and latched request.
//    Outside ISSUE: r_en=0, layer_r=0, r_address=0, cntb=0.
//  - Capture: a 1-stage delay of {r_en, cntb} qualifies b_out. b_out sampled
//    one edge after the issuing cycle is written into the vec_out slot for that
//    beat, with the lane mask applied.
//  - Latency: legal request accepted at edge E0 -> r_en high for cycles E0..E(n-1)
//    -> vec_valid high after E(n+1) (2 cycles for n=1, 5 for n=4).
//    Illegal request -> vec_valid 1 cycle after acceptance.
//  - No overlap: the next request is accepted only in IDLE, at the earliest the
//    cycle after the vec handshake.
//  - Reset mid-operation aborts immediately: r_en drops asynchronously and the
//    partial vector is discarded.
// TESTING
//  1. Layer 8, addr 3; stub returns beat k = all lanes (k+1) -> r_address=3 with
//     cntb 0,1,2,3 on 4 consecutive cycles; vec_valid 5 cycles after accept;
//     vec_out beat k lanes == k+1.
//  2. Layer 3, addr 10; stub drives 0x3F on all 32 lanes -> single r_en cycle,
//     cntb=0; vec_out lanes 0..7 = 0x3F, lanes 8..127 = 0.
//  3. Layer 7 with vec_ready held 0 for 10 cycles -> vec_out and vec_valid stable;
//     req_ready=0 and r_en=0 throughout; IDLE one cycle after vec_ready=1.
//  4. Layers 0 and 9 -> no r_en; vec_valid 1 cycle after accept, vec_err=1,
//     vec_out=0.
//  5. rst pulsed during cycle 2 of a layer-8 issue -> r_en=0 and vec_valid=0
//     immediately; after release a layer-1 request completes normally
//     (2 valid lanes).
//  6. req_valid held high, layer 6 then layer 5 -> second request accepted the
//     cycle after the first vec handshake; both vectors correct.

Source files
------------

// File: rtl/beta_fetch_ctrl.sv
// Beta storage read sequencer: issues per-beat storage reads for one node and
// assembles the zero-masked 4*P-lane vector handed to the PE array.
module beta_fetch_ctrl #(
  parameter int P = 32,
  parameter int Q = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [4:0]         req_layer,
  input  logic [8:0]         req_addr,
  output logic               r_en,
  output logic [4:0]         layer_r,
  output logic [8:0]         r_address,
  output logic [4:0]         cntb,
  input  logic [P*Q-1:0]     b_out,
  output logic               vec_valid,
  input  logic               vec_ready,
  output logic [4*P*Q-1:0]   vec_out,
  output logic               vec_err,
  output logic [1:0]         dbg_state
);

  localparam int PQ = P * Q;

  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both high; req_* is accepted only in IDLE, vec_* is offered only in DONE
  // and vec_out/vec_err hold steady until the consumer takes them.
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t       state, state_nx;
  logic [4:0]   lat_layer;
  logic [8:0]   lat_addr;
  logic [1:0]   beat_cnt;
  logic [1:0]   last_beat;
  logic [5:0]   lane_cnt;
  logic [PQ-1:0] lane_mask;
  logic         cap_valid;
  logic [1:0]   cap_beat;
  logic         req_fire;
  logic         layer_ok;

  assign req_fire  = req_valid && req_ready;
  assign layer_ok  = (req_layer != 5'd0) && (req_layer <= 5'd8);
  assign dbg_state = state;

  always_comb begin
    last_beat = 2'd0;
    if (lat_layer == 5'd8)      last_beat = 2'd3;
    else if (lat_layer == 5'd7) last_beat = 2'd1;
  end

  // Layers 1..4 hold 2^layer meaningful lanes; deeper layers fill the beat.
  always_comb begin
    lane_cnt  = 6'd32;
    lane_mask = '0;
    if (lat_layer < 5'd5) lane_cnt = 6'd1 << lat_layer[2:0];
    for (int l = 0; l < P; l++) begin
      if (l < int'(lane_cnt)) lane_mask[l*Q +: Q] = '1;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req_fire) state_nx = layer_ok ? ISSUE : DONE;
      ISSUE:   if (beat_cnt == last_beat) state_nx = DRAIN;
      DRAIN:   state_nx = DONE;
      DONE:    if (vec_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    vec_valid = 1'b0;
    r_en      = 1'b0;
    layer_r   = 5'd0;
    r_address = 9'd0;
    cntb      = 5'd0;
    case (state)
      IDLE:  req_ready = 1'b1;
      ISSUE: begin
        r_en      = 1'b1;
        layer_r   = lat_layer;
        r_address = lat_addr;
        cntb      = {3'b000, beat_cnt};
      end
      DONE:  vec_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Storage returns data one cycle after r_en, so the delayed {r_en, cntb}
  // marks which slot the current b_out belongs to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_layer <= 5'd0;
      lat_addr  <= 9'd0;
      beat_cnt  <= 2'd0;
      cap_valid <= 1'b0;
      cap_beat  <= 2'd0;
      vec_out   <= '0;
      vec_err   <= 1'b0;
    end else begin
      cap_valid <= r_en;
      cap_beat  <= beat_cnt;
      if (req_fire) begin
        lat_layer <= req_layer;
        lat_addr  <= req_addr;
        beat_cnt  <= 2'd0;
        vec_out   <= '0;
        vec_err   <= !layer_ok;
      end else begin
        if (state == ISSUE) beat_cnt <= beat_cnt + 2'd1;
        if (cap_valid) vec_out[int'(cap_beat)*PQ +: PQ] <= b_out & lane_mask;
      end
    end
  end

endmodule

// File: tb/tb_beta_fetch_ctrl.sv
// Bench for beta_fetch_ctrl: storage stub with 1-cycle read latency and a
// scoreboard of expected vectors pushed at request time.
module tb_beta_fetch_ctrl;
  localparam int P  = 32;
  localparam int Q  = 6;
  localparam int PQ = P * Q;
  localparam int VW = 4 * PQ;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready;
  logic [4:0]    req_layer;
  logic [8:0]    req_addr;
  logic          r_en;
  logic [4:0]    layer_r;
  logic [8:0]    r_address;
  logic [4:0]    cntb;
  logic [PQ-1:0] b_out;
  logic          vec_valid, vec_ready;
  logic [VW-1:0] vec_out;
  logic          vec_err;
  logic [1:0]    dbg_state;

  int errors = 0;
  int checks = 0;

  logic [VW-1:0] exp_q[$];
  logic          exp_err_q[$];
  logic [PQ-1:0] stub_beat[2][4];

  beta_fetch_ctrl #(.P(P), .Q(Q)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_layer(req_layer), .req_addr(req_addr),
    .r_en(r_en), .layer_r(layer_r), .r_address(r_address), .cntb(cntb),
    .b_out(b_out),
    .vec_valid(vec_valid), .vec_ready(vec_ready),
    .vec_out(vec_out), .vec_err(vec_err),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Storage stub: registered read, data selected by address bit 0 and beat.
  always @(posedge clk) begin
    if (r_en) b_out <= stub_beat[r_address[0]][cntb[1:0]];
  end

  function automatic logic [VW-1:0] model_vec(input int layer, input int sel);
    logic [VW-1:0] v;
    int n, lanes;
    v = '0;
    if (layer < 1 || layer > 8) return v;
    n     = (layer == 8) ? 4 : (layer == 7) ? 2 : 1;
    lanes = (layer >= 5) ? 32 : (1 << layer);
    for (int k = 0; k < n; k++)
      for (int l = 0; l < lanes; l++)
        v[k*PQ + l*Q +: Q] = stub_beat[sel][k][l*Q +: Q];
    return v;
  endfunction

  task automatic fill_random();
    for (int s = 0; s < 2; s++)
      for (int k = 0; k < 4; k++)
        for (int l = 0; l < P; l++)
          stub_beat[s][k][l*Q +: Q] = 6'($urandom_range(0, 63));
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive a request at a negedge; returns at the negedge after acceptance.
  task automatic send_req(input int layer, input int addr, input bit push);
    req_valid = 1'b1;
    req_layer = 5'(layer);
    req_addr  = 9'(addr);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL req_ready_before_send: got %b expected 1", req_ready);
    end
    if (push) begin
      exp_q.push_back(model_vec(layer, addr & 1));
      exp_err_q.push_back((layer < 1 || layer > 8) ? 1'b1 : 1'b0);
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Wait (bounded) for vec_valid, compare against scoreboard, complete handshake.
  task automatic take_vec(input string name);
    logic [VW-1:0] e;
    logic          ee;
    for (int i = 0; i < 20 && vec_valid !== 1'b1; i++) @(negedge clk);
    checks++;
    if (vec_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s_timeout: vec_valid=%b expected 1", name, vec_valid);
      return;
    end
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s_empty_scoreboard: got vector with no expectation", name);
      return;
    end
    e  = exp_q.pop_front();
    ee = exp_err_q.pop_front();
    checks++;
    if (vec_out !== e) begin
      errors++;
      $display("FAIL %s_vec: got %h expected %h", name, vec_out, e);
    end
    checks++;
    if (vec_err !== ee) begin
      errors++;
      $display("FAIL %s_err: got %b expected %b", name, vec_err, ee);
    end
    vec_ready = 1'b1;
    @(negedge clk);
    vec_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 1'b0; req_layer = '0; req_addr = '0; vec_ready = 1'b0;
    b_out = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_req_ready", 64'(req_ready), 64'd1);
    chk("reset_r_en", 64'(r_en), 64'd0);
    chk("reset_vec_valid", 64'(vec_valid), 64'd0);
    chk("reset_vec_err", 64'(vec_err), 64'd0);
    chk("reset_vec_out_zero", 64'(vec_out != '0), 64'd0);
    chk("reset_addr_cntb", 64'({layer_r, r_address, cntb}), 64'd0);
  endtask

  task automatic test_layer8();
    for (int s = 0; s < 2; s++)
      for (int k = 0; k < 4; k++)
        for (int l = 0; l < P; l++) stub_beat[s][k][l*Q +: Q] = 6'(k + 1);
    send_req(8, 3, 1'b1);
    for (int k = 0; k < 4; k++) begin
      chk("l8_r_en", 64'(r_en), 64'd1);
      chk("l8_r_address", 64'(r_address), 64'd3);
      chk("l8_layer_r", 64'(layer_r), 64'd8);
      chk("l8_cntb", 64'(cntb), 64'(k));
      @(negedge clk);
    end
    chk("l8_drain_r_en", 64'(r_en), 64'd0);
    chk("l8_drain_vec_valid", 64'(vec_valid), 64'd0);
    @(negedge clk);
    chk("l8_latency_vec_valid", 64'(vec_valid), 64'd1);
    chk("l8_beat3_lane31", 64'(vec_out[3*PQ + 31*Q +: Q]), 64'd4);
    take_vec("l8");
  endtask

  task automatic test_layer3_mask();
    for (int s = 0; s < 2; s++)
      for (int k = 0; k < 4; k++) stub_beat[s][k] = '1;
    send_req(3, 10, 1'b1);
    chk("l3_r_en", 64'(r_en), 64'd1);
    chk("l3_cntb", 64'(cntb), 64'd0);
    chk("l3_r_address", 64'(r_address), 64'd10);
    @(negedge clk);
    chk("l3_single_beat", 64'(r_en), 64'd0);
    @(negedge clk);
    chk("l3_lane7", 64'(vec_out[7*Q +: Q]), 64'h3f);
    chk("l3_lane8", 64'(vec_out[8*Q +: Q]), 64'h0);
    take_vec("l3");
  endtask

  task automatic test_backpressure();
    logic [VW-1:0] held;
    fill_random();
    send_req(7, 5, 1'b1);
    for (int i = 0; i < 10 && vec_valid !== 1'b1; i++) @(negedge clk);
    held = vec_out;
    for (int i = 0; i < 10; i++) begin
      chk("bp_vec_valid", 64'(vec_valid), 64'd1);
      chk("bp_req_ready", 64'(req_ready), 64'd0);
      chk("bp_r_en", 64'(r_en), 64'd0);
      checks++;
      if (vec_out !== held) begin
        errors++;
        $display("FAIL bp_vec_stable: got %h expected %h", vec_out, held);
      end
      @(negedge clk);
    end
    take_vec("bp");
    chk("bp_idle_req_ready", 64'(req_ready), 64'd1);
    chk("bp_idle_state", 64'(dbg_state), 64'd0);
  endtask

  task automatic test_illegal();
    int layers[2] = '{0, 9};
    for (int i = 0; i < 2; i++) begin
      send_req(layers[i], 7, 1'b1);
      chk("ill_no_r_en", 64'(r_en), 64'd0);
      chk("ill_vec_valid", 64'(vec_valid), 64'd1);
      take_vec("illegal");
    end
  endtask

  task automatic test_reset_abort();
    fill_random();
    send_req(8, 2, 1'b0);
    @(negedge clk);
    chk("abort_pre_r_en", 64'(r_en), 64'd1);
    rst = 1'b1;
    #1;
    chk("abort_r_en", 64'(r_en), 64'd0);
    chk("abort_vec_valid", 64'(vec_valid), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_vec_cleared", 64'(vec_out != '0), 64'd0);
    send_req(1, 4, 1'b1);
    take_vec("after_abort");
  endtask

  task automatic test_back_to_back();
    fill_random();
    req_valid = 1'b1;
    req_layer = 5'd6;
    req_addr  = 9'd20;
    exp_q.push_back(model_vec(6, 0));
    exp_err_q.push_back(1'b0);
    @(negedge clk);
    req_layer = 5'd5;
    req_addr  = 9'd21;
    exp_q.push_back(model_vec(5, 1));
    exp_err_q.push_back(1'b0);
    chk("b2b_busy", 64'(req_ready), 64'd0);
    take_vec("b2b_first");
    chk("b2b_ready_after_hs", 64'(req_ready), 64'd1);
    @(negedge clk);
    req_valid = 1'b0;
    chk("b2b_second_r_en", 64'(r_en), 64'd1);
    chk("b2b_second_addr", 64'(r_address), 64'd21);
    take_vec("b2b_second");
    chk("b2b_queue_drained", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    test_reset();
    test_layer8();
    test_layer3_mask();
    test_backpressure();
    test_illegal();
    test_reset_abort();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
